// File: rtl/tinyalu_result_capture.sv
// Captures completed TinyALU operations as 36-bit records and buffers them
// in a small FIFO drained through a valid/ready port.
module tinyalu_result_capture #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [7:0]               A,
  input  logic [7:0]               B,
  input  logic [2:0]               op,
  input  logic                     start,
  input  logic                     done,
  input  logic [15:0]              result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [35:0]              out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               drop_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, WAIT_LOW} state_t;

  state_t        state;
  logic [7:0]    a_l;
  logic [7:0]    b_l;
  logic [2:0]    op_l;
  logic [7:0]    tcnt;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [35:0]   mem [DEPTH];

  logic          push;
  logic [35:0]   push_data;
  logic          pop;
  logic          full;
  logic          wr_en;

  // done takes priority over a timeout landing on the same edge
  always_comb begin
    push      = 1'b0;
    push_data = '0;
    if (state == BUSY) begin
      if (done) begin
        push      = 1'b1;
        push_data = {1'b0, op_l, a_l, b_l, result};
      end else if (tcnt == 8'(TIMEOUT - 1)) begin
        push      = 1'b1;
        push_data = {1'b1, op_l, a_l, b_l, 16'h0000};
      end
    end
  end

  assign full      = (count == (AW + 1)'(DEPTH));
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];
  assign pop       = out_valid & out_ready;
  assign wr_en     = push & (~full | pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      a_l   <= '0;
      b_l   <= '0;
      op_l  <= '0;
      tcnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (op != 3'b000) begin
              a_l   <= A;
              b_l   <= B;
              op_l  <= op;
              tcnt  <= '0;
              state <= BUSY;
            end else begin
              state <= WAIT_LOW;
            end
          end
        end
        BUSY: begin
          if (push) state <= WAIT_LOW;
          else      tcnt  <= tcnt + 8'd1;
        end
        WAIT_LOW: begin
          if (!start) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      drop_count <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && full && !pop && drop_count != 8'hFF)
        drop_count <= drop_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_tinyalu_result_capture.sv
// Randomized bench for tinyalu_result_capture: operations are issued at
// transaction level and expected records are tracked in a queue scoreboard.
module tb_tinyalu_result_capture;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  A, B;
  logic [2:0]  op;
  logic        start, done, out_ready;
  logic [15:0] result;
  logic        out_valid;
  logic [35:0] out_data;
  logic [$clog2(DEPTH):0] count;
  logic [7:0]  drop_count;

  always #5 clk = ~clk;

  tinyalu_result_capture #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .A(A), .B(B), .op(op), .start(start),
    .done(done), .result(result), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .count(count), .drop_count(drop_count)
  );

  int checks = 0;
  int errors = 0;
  logic [35:0] q[$];
  int exp_drop = 0;
  int rdy_mode = 2;
  int done_rdy = -1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic pick_rdy();
    case (rdy_mode)
      0:       return 1'b0;
      1:       return 1'b1;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  function automatic logic [15:0] alu_res(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o);
    case (o)
      3'd1:    return 16'(a) + 16'(b);
      3'd2:    return {8'h00, a & b};
      3'd3:    return {8'h00, a ^ b};
      3'd4:    return 16'(a) * 16'(b);
      default: return 16'h0000;
    endcase
  endfunction

  // One clock edge: update the scoreboard with the expected push/pop, then check
  task automatic tick(input logic push, input logic [35:0] rec, input logic rdy);
    logic do_pop;
    out_ready = rdy;
    do_pop = rdy && (q.size() > 0);
    @(posedge clk); #1;
    if (do_pop) void'(q.pop_front());
    if (push) begin
      if (q.size() < DEPTH) q.push_back(rec);
      else if (exp_drop < 255) exp_drop++;
    end
    check_eq("out_valid", out_valid, q.size() > 0);
    check_eq("count", count, q.size());
    check_eq("drop_count", drop_count, exp_drop);
    if (q.size() > 0) check_eq("out_data", out_data, q[0]);
  endtask

  // Issue one operation; done arrives on BUSY cycle lat, start held hold extra cycles
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o,
                       input int lat, input int hold);
    logic [15:0] r;
    logic fin;
    logic rdy;
    r = alu_res(a, b, o);
    A = a; B = b; op = o; start = 1'b1; done = 1'b0;
    tick(1'b0, '0, pick_rdy());
    if (o != 3'd0) begin
      A = 8'($urandom); B = 8'($urandom);
      fin = 1'b0;
      for (int k = 1; k <= TIMEOUT && !fin; k++) begin
        if (k == lat) begin
          done = 1'b1; result = r;
          rdy = (done_rdy >= 0) ? (done_rdy != 0) : pick_rdy();
          tick(1'b1, {1'b0, o, a, b, r}, rdy);
          done = 1'b0; result = 16'($urandom);
          fin = 1'b1;
        end else if (k == TIMEOUT) begin
          tick(1'b1, {1'b1, o, a, b, 16'h0000}, pick_rdy());
          fin = 1'b1;
        end else begin
          tick(1'b0, '0, pick_rdy());
        end
      end
    end
    for (int h = 0; h < hold; h++) begin
      done = 1'($urandom_range(0, 1)); result = 16'($urandom);
      tick(1'b0, '0, pick_rdy());
    end
    done = 1'b0; start = 1'b0;
    tick(1'b0, '0, pick_rdy());
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH + 2 && q.size() > 0; i++) tick(1'b0, '0, 1'b1);
    check_eq("drain_count", count, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; A = '0; B = '0; op = '0; start = 1'b0; done = 1'b0;
    result = '0; out_ready = 1'b0;
    #12;
    check_eq("reset_valid", out_valid, 0);
    check_eq("reset_count", count, 0);
    check_eq("reset_drop", drop_count, 0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    rdy_mode = 0;
    do_op(8'h12, 8'h34, 3'd1, 1, 0);
    check_eq("add_record", out_data, 36'h1_1234_0046);
    check_eq("add_count", count, 1);
    tick(1'b0, '0, 1'b1);
    check_eq("add_popped", out_valid, 0);

    do_op(8'hFF, 8'hFF, 3'd4, 3, 0);
    check_eq("mul_record", out_data, 36'h4_FFFF_FE01);
    drain();

    do_op(8'h55, 8'hAA, 3'd0, 1, 3);
    check_eq("noop_count", count, 0);

    do_op(8'hF0, 8'h0F, 3'd2, 100, 4);
    check_eq("timeout_record", out_data, 36'hA_F00F_0000);
    check_eq("timeout_single", count, 1);
    drain();

    // overflow: ten operations into an eight-entry FIFO
    for (int i = 0; i < 10; i++) do_op(8'(i), 8'(i * 3), 3'd1, 1, 0);
    check_eq("ovf_count", count, DEPTH);
    check_eq("ovf_drop", drop_count, 2);
    drain();

    // full FIFO with push and pop on the same edge
    for (int i = 0; i < DEPTH; i++) do_op(8'(8'h40 + i), 8'h01, 3'd3, 2, 0);
    done_rdy = 1;
    do_op(8'hC3, 8'h3C, 3'd2, 2, 0);
    done_rdy = -1;
    check_eq("full_pp_count", count, DEPTH);
    check_eq("full_pp_drop", drop_count, 2);
    check_eq("full_pp_last", q[q.size() - 1], 36'h2_C33C_0000);
    drain();

    // reset asserted between edges while BUSY
    rdy_mode = 0;
    do_op(8'h01, 8'h02, 3'd1, 1, 0);
    A = 8'h77; B = 8'h66; op = 3'd1; start = 1'b1;
    tick(1'b0, '0, 1'b0);
    tick(1'b0, '0, 1'b0);
    #3 reset_n = 1'b0;
    #1;
    q.delete(); exp_drop = 0;
    check_eq("midrst_valid", out_valid, 0);
    check_eq("midrst_count", count, 0);
    check_eq("midrst_drop", drop_count, 0);
    start = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    done = 1'b1; result = 16'h1234;
    tick(1'b0, '0, 1'b0);
    done = 1'b0;
    tick(1'b0, '0, 1'b0);

    // randomized operations with random backpressure
    rdy_mode = 2;
    for (int i = 0; i < 60; i++)
      do_op(8'($urandom), 8'($urandom), 3'($urandom_range(0, 4)),
            $urandom_range(1, TIMEOUT + 3), $urandom_range(0, 2));
    drain();

    // drop counter saturation
    rdy_mode = 0;
    for (int i = 0; i < DEPTH + 260; i++) do_op(8'(i), 8'h11, 3'd1, 1, 0);
    check_eq("drop_sat", drop_count, 255);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tinyalu_result_capture.md
# tinyalu_result_capture

Synthesizable producer for the TinyALU result stream. Watches the TinyALU operand/control/result bus, packages each completed operation as a 36-bit record, and buffers records in a small FIFO with a valid/ready drain port. This is the hardware write side of the result channel that downstream checkers and printers consume.

## Interface

- DEPTH, 8, FIFO entries; power of two, minimum 2.
- TIMEOUT, 15, cycles in BUSY without done before an error record is emitted; range 1–255.

- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- A  input  8  TinyALU operand A.
- B  input  8  TinyALU operand B.
- op  input  3  TinyALU opcode: 000 no_op, 001 add, 010 and, 011 xor, 100 mul.
- start  input  1  TinyALU start; held high by the driver until done.
- done  input  1  TinyALU done.
- result  input  16  TinyALU result, valid while done is high.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts the head record when out_valid is high.
- out_data  output  36  head record {err[35], op[34:32], A[31:24], B[23:16], result[15:0]}.
- count  output  $clog2(DEPTH)+1  current occupancy.
- drop_count  output  8  saturating count of records lost to a full FIFO.

## Operation

- FSM states: IDLE, BUSY, WAIT_LOW.
- IDLE: start=1 and op≠000 -> latch A, B, op; clear timeout counter; go to BUSY. start=1 with op=000 -> go to WAIT_LOW; nothing is captured. A start that is high when reset deasserts counts as a new start.
- BUSY: done=1 -> push {0, op_l, A_l, B_l, result}; go to WAIT_LOW. Otherwise increment the timeout counter. When the counter reaches TIMEOUT -> push {1, op_l, A_l, B_l, 16'h0000}; go to WAIT_LOW.
- WAIT_LOW: stay until start=0, then go to IDLE. This prevents one long start pulse from being captured twice.
- The latched operands are used for the record, not live A/B at done time.
- Push with FIFO full and no pop in the same cycle: record is discarded and drop_count increments, saturating at 255.
- Push and pop in the same cycle: both succeed, including when full; count is unchanged.
- Pop occurs on a cycle where out_valid=1 and out_ready=1. Pop when empty is a no-op.
- Pointers wrap modulo DEPTH. count is maintained explicitly, and full is count==DEPTH.

## Timing

- Reset (asynchronous assertion) drives these values immediately: state=IDLE, pointers=0, count=0, out_valid=0, drop_count=0, timeout counter=0.
- After reset, out_data is don't-care while out_valid=0. FIFO storage is not reset.
- Reset asserted mid-operation abandons the operation; no record is produced.
- Operands are latched on the clk edge where IDLE samples start=1.
- A done sampled high on edge N pushes the record at edge N.
  - out_valid=1 and count updated after edge N, with out_data=the record if the FIFO was empty.
  - Capture latency is one cycle from done to out_valid.
- done is only honoured in BUSY. A done sampled in IDLE or WAIT_LOW is ignored.
- Timeout: the error record is pushed on the edge that completes TIMEOUT consecutive BUSY cycles without done.
- out_data and out_valid are driven from registered state only, with no combinational path from inputs.
- After start drops, back-to-back operations are accepted with one WAIT_LOW/IDLE cycle between them. Throughput is at most one record per 3 cycles.

## Test plan

- Reset and single add:
  - Stimulus: A=8'h12, B=8'h34, op=001, start high; done with result=16'h0046 one cycle later; start low.
  - Required: out_valid rises the cycle after done; out_data=36'h0_1_12_34_0046 (err=0); count=1.
  - Then out_ready=1 for one cycle -> out_valid=0, count=0.
- Multiply with operand change:
  - Stimulus: A=8'hFF, B=8'hFF, op=100; A/B driven to 8'h00 while busy; done after 3 cycles with result=16'hFE01.
  - Required: out_data={0,100,FF,FF,FE01}.
- no_op and timeout:
  - op=000 with start -> no record, count stays 0.
  - op=010, A=8'hF0, B=8'h0F, done never asserted -> after 15 BUSY cycles, record err=1, result=0; no second record while start is still high.
- Overflow:
  - Stimulus: 10 add operations with out_ready=0 and DEPTH=8.
  - Required: count=8, drop_count=2; draining yields the first 8 records in order, with pointers wrapping correctly.
- Full with simultaneous push and pop:
  - Stimulus: FIFO full, done arrives in the same cycle as out_ready=1.
  - Required: count stays 8, drop_count unchanged, and the new record appears last.
- Reset mid-operation:
  - Stimulus: assert reset_n=0 in BUSY, asynchronously between edges.
  - Required: out_valid=0 and count=0 immediately; a subsequent done with start low produces no record.
